// File: rtl/lc3_imm_pipe_pkg.sv
// lc3_imm_pkg: field selects, field widths and counter limit for the LC-3 immediate pipe
package lc3_imm_pkg;
  typedef enum logic [2:0] {
    SEL_IMM5    = 3'd0,
    SEL_OFF6    = 3'd1,
    SEL_PCOFF9  = 3'd2,
    SEL_PCOFF11 = 3'd3,
    SEL_TRAP8   = 3'd4
  } imm_sel_e;
  localparam int IMM5_W    = 5;
  localparam int OFF6_W    = 6;
  localparam int PCOFF9_W  = 9;
  localparam int PCOFF11_W = 11;
  localparam int TRAP8_W   = 8;
  localparam logic [7:0] ERR_SAT = 8'd255;
endpackage

// File: rtl/lc3_imm_pipe_if.sv
// lc3_imm_pipe_if: upstream/downstream handshake bundle of the immediate pipe
interface lc3_imm_pipe_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_ir;
  logic [2:0]        in_sel;
  logic [DATA_W-1:0] in_base;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;
  logic [7:0]        err_count;
  modport master (
    output in_valid, in_ir, in_sel, in_base, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err, err_count
  );
  modport slave (
    input  in_valid, in_ir, in_sel, in_base, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err, err_count
  );
endinterface

// File: rtl/lc3_imm_field_ext.sv
// lc3_imm_field_ext: picks one IR field and sign/zero-extends it, flagging illegal selects
module lc3_imm_field_ext
  import lc3_imm_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       i_ir,
  input  logic [2:0]        i_sel,
  output logic [DATA_W-1:0] o_ext,
  output logic              o_err
);
  // Illegal selects extend to zero so the adder stage yields the bare base
  always_comb begin
    o_err = i_sel > SEL_TRAP8;
    o_ext = i_sel == SEL_IMM5    ? {{(DATA_W-IMM5_W){i_ir[IMM5_W-1]}}, i_ir[IMM5_W-1:0]} :
            i_sel == SEL_OFF6    ? {{(DATA_W-OFF6_W){i_ir[OFF6_W-1]}}, i_ir[OFF6_W-1:0]} :
            i_sel == SEL_PCOFF9  ? {{(DATA_W-PCOFF9_W){i_ir[PCOFF9_W-1]}}, i_ir[PCOFF9_W-1:0]} :
            i_sel == SEL_PCOFF11 ? {{(DATA_W-PCOFF11_W){i_ir[PCOFF11_W-1]}}, i_ir[PCOFF11_W-1:0]} :
            i_sel == SEL_TRAP8   ? {{(DATA_W-TRAP8_W){1'b0}}, i_ir[TRAP8_W-1:0]} :
                                   '0;
  end
endmodule

// File: rtl/lc3_imm_pipe.sv
// lc3_imm_pipe: pipelined LC-3 immediate/offset generator; LC3_IMM_ADDER_EN adds the base-adder stage B
module lc3_imm_pipe
  import lc3_imm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
) (
  input logic         clk,
  input logic         rst_n,
  lc3_imm_pipe_if.slave bus
);
  logic [DATA_W-1:0] w_ext;
  logic              w_err;
  logic              w_a_load;
  logic              w_a_down_rdy;
  logic              w_accept;
  logic              r_a_valid;
  logic [DATA_W-1:0] r_a_ext;
  logic [TAG_W-1:0]  r_a_tag;
  logic              r_a_err;
  logic [7:0]        r_err_count;

  lc3_imm_field_ext #(.DATA_W(DATA_W)) u_ext (
    .i_ir  (bus.in_ir),
    .i_sel (bus.in_sel),
    .o_ext (w_ext),
    .o_err (w_err)
  );

  assign w_a_load      = !r_a_valid || w_a_down_rdy;
  assign w_accept      = bus.in_valid && w_a_load;
  assign bus.in_ready  = w_a_load;
  assign bus.err_count = r_err_count;

  // Stage A: capture the extended field on accept, refill bubbles immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a_ext   <= '0;
      r_a_tag   <= '0;
      r_a_err   <= 1'b0;
    end else begin
      r_a_valid <= w_a_load ? bus.in_valid : r_a_valid;
      r_a_ext   <= w_accept ? w_ext : r_a_ext;
      r_a_tag   <= w_accept ? bus.in_tag : r_a_tag;
      r_a_err   <= w_accept ? w_err : r_a_err;
    end
  end

  // Illegal selects are counted only when actually accepted, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_count <= '0;
    else r_err_count <= (w_accept && w_err && r_err_count != ERR_SAT) ? r_err_count + 8'd1 : r_err_count;
  end

`ifdef LC3_IMM_ADDER_EN
  logic [DATA_W-1:0] r_a_base;
  logic              r_b_valid;
  logic [DATA_W-1:0] r_b_sum;
  logic [TAG_W-1:0]  r_b_tag;
  logic              r_b_err;

  assign w_a_down_rdy  = !r_b_valid || bus.out_ready;
  assign bus.out_valid = r_b_valid;
  assign bus.out_data  = r_b_sum;
  assign bus.out_tag   = r_b_tag;
  assign bus.out_err   = r_b_err;

  // Base rides alongside stage A so the add happens on the way into stage B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_a_base <= '0;
    else r_a_base <= w_accept ? bus.in_base : r_a_base;
  end

  // Stage B: base + field, modulo 2^DATA_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_valid <= 1'b0;
      r_b_sum   <= '0;
      r_b_tag   <= '0;
      r_b_err   <= 1'b0;
    end else begin
      r_b_valid <= w_a_down_rdy ? r_a_valid : r_b_valid;
      r_b_sum   <= (w_a_down_rdy && r_a_valid) ? r_a_base + r_a_ext : r_b_sum;
      r_b_tag   <= (w_a_down_rdy && r_a_valid) ? r_a_tag : r_b_tag;
      r_b_err   <= (w_a_down_rdy && r_a_valid) ? r_a_err : r_b_err;
    end
  end
`else
  logic w_unused;

  assign w_unused      = ^bus.in_base;
  assign w_a_down_rdy  = bus.out_ready;
  assign bus.out_valid = r_a_valid;
  assign bus.out_data  = r_a_ext;
  assign bus.out_tag   = r_a_tag;
  assign bus.out_err   = r_a_err;
`endif
endmodule

// File: doc/lc3_imm_pipe.md
# lc3_imm_pipe

Pipelined immediate/offset generator for the LC-3 datapath. It extracts one instruction-register field (imm5, offset6, PCoffset9, PCoffset11 or trapvect8), sign- or zero-extends it to a parametrised datapath width, and can add a base address to it. A valid/ready handshake lets it sit between the decode stage and the address/ALU operand muxes, replacing the fixed-width combinational extenders and absorbing back-pressure from downstream stages.

## Interface
- `DATA_W`, 16: output datapath width; legal range 12..32.
- `TAG_W`, 4: width of the sideband tag carried alongside each item.
- `clk` in 1: sole clock; everything samples on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream item present.
- `in_ready` out 1: block can accept an item this cycle.
- `in_ir` in 16: instruction register.
- `in_sel` in 3: field select; encoding under Operation.
- `in_base` in DATA_W: base address (PC or register). Used only when the adder is compiled in; ignored otherwise.
- `in_tag` in TAG_W: sideband, passed through unchanged.
- `out_valid` out 1: result present.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out DATA_W: extended field, or base plus field.
- `out_tag` out TAG_W: tag of the item on `out_data`.
- `out_err` out 1: item had an illegal `in_sel`.
- `err_count` out 8: saturating count of illegal selects accepted.

## Operation
- Field select encoding (`in_sel`):
  - 0: `ir[4:0]`, sign-extended.
  - 1: `ir[5:0]`, sign-extended.
  - 2: `ir[8:0]`, sign-extended.
  - 3: `ir[10:0]`, sign-extended.
  - 4: `ir[7:0]`, zero-extended.
  - 5..7: illegal. Extended value is 0, the item's `err` flag is set, and `err_count` increments at acceptance. `err_count` saturates at 255.
- Stage A register holds {valid, extended value, base, tag, err}.
- Stage B register exists only with the adder compiled in. It holds {valid, base + extended value, tag, err}.
- Addition is modulo 2^DATA_W; wrap is silent. For an err item, B output = base + 0.
- Each stage loads when its valid is 0 or its downstream consumer is ready (standard pipeline advance). A bubble is filled in the same cycle.
- `in_ready` = NOT A.valid OR A advances. This is a combinational path from `out_ready`; no skid buffer is used.
- Ordering is strictly FIFO. No item is dropped or duplicated except at reset.
- While `out_valid` is high and `out_ready` is low, `out_data`, `out_tag` and `out_err` hold stable.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_tag`=0, `out_err`=0, `err_count`=0. `in_ready`=1 once `rst_n` is high.
- Latency from acceptance (`in_valid` and `in_ready` at edge N) to `out_valid`:
  - without the adder, high after edge N (1 cycle);
  - with the adder, high after edge N+1 (2 cycles).
- Throughput is 1 item per cycle with `out_ready` held high.
- Simultaneous accept and retire in the same cycle on a full pipe: both occur and occupancy is unchanged.
- Asserting reset mid-operation clears all valids and `err_count` immediately and asynchronously. In-flight items are discarded. Nothing is emitted after release until new input arrives.
- An illegal select held off by `in_ready`=0 is not counted until it is accepted.

## Configuration
- `LC3_IMM_ADDER_EN` defined: stage B and the base adder are present. Latency is 2 and `out_data` = base + field.
- Undefined: no stage B. `in_base` is unused and its register bits are optimised away. Latency is 1 and `out_data` = extended field.

## Structure
- Package `lc3_imm_pkg` holds:
  - `imm_sel_e` enum (`SEL_IMM5`, `SEL_OFF6`, `SEL_PCOFF9`, `SEL_PCOFF11`, `SEL_TRAP8`);
  - field-width constants 5/6/9/11/8;
  - the `err_count` saturation constant.
- Sub-module `lc3_imm_field_ext`: purely combinational. It takes ir, sel and DATA_W and produces the extended value plus the illegal flag. It is instantiated once, ahead of stage A.

## Test plan
- sel=0, ir=0x1030, no adder → `out_data`=0xFFF0 one cycle after accept.
  - With adder and base=0x3000 → 0x2FF0 two cycles after accept.
- sel=4, ir=0xF0FF → 0x00FF (zero-extended).
  - sel=3, ir=0x4C00, base=0x0100, adder → 0xFD00.
- Wrap: sel=2, ir=0x00FF, base=0xFF80, adder → 0x007F with no flag.
- Back-pressure: `out_ready`=0 for 4 cycles while 3 tagged items (tags 1, 2, 3) are offered.
  - `in_ready` drops once the pipe is full, and `out_data`/`out_tag` stay stable.
  - On release, tags emerge in order 1, 2, 3 on consecutive cycles.
- Illegal: sel=6 → `out_data`=0 (or base with the adder), `out_err`=1, `err_count`=1.
  - 300 illegal items → `err_count`=255.
- Reset with 2 items in flight: `out_valid` goes to 0 without waiting for a clock edge and `err_count`=0. After release, no output appears until new input.
